// File: rtl/key_pkg.sv
// key_pkg: shared constants for the key debounce slice.
//   - FSM state encoding (2-bit, legacy-compatible localparams)
//   - default debounce and auto-repeat periods
package key_pkg;

    localparam logic [1:0] ST_RELEASED     = 2'd0;
    localparam logic [1:0] ST_WAIT_PRESS   = 2'd1;
    localparam logic [1:0] ST_PRESSED      = 2'd2;
    localparam logic [1:0] ST_WAIT_RELEASE = 2'd3;

    localparam int DB_CYCLES_DEFAULT     = 4;
    localparam int REPEAT_CYCLES_DEFAULT = 8;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for asynchronous inputs.
// Ports:
//   clk   in   sampling clock
//   rst_n in   asynchronous active-low reset; both flops load RST_VAL
//   d     in   asynchronous input
//   q     out  synchronised output (two clk edges of latency)
module sync_2ff #(
    parameter int           WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_d, meta_q;
    logic [WIDTH-1:0] sync_d, sync_q;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/key_debounce_pulse.sv
// key_debounce_pulse: conditions a raw active-low push-button into a clean
// pressed level plus one-cycle press/release pulses for a downstream counter.
// Optional feature macro: KEY_DEBOUNCE_AUTO_REPEAT_EN -- when defined, holding
// the key in the stable pressed state emits an extra press_pulse every
// REPEAT_CYCLES cycles.
// Ports:
//   ck          in   clock, all state updates on the rising edge
//   res         in   asynchronous active-low reset
//   key_n       in   raw button, 0 = pressed, asynchronous, may bounce
//   key_level   out  debounced level, 1 = pressed (registered)
//   press_pulse out  one-cycle pulse on accepted press (registered)
//   rel_pulse   out  one-cycle pulse on accepted release (registered)
//   dbg_state   out  current FSM state (key_pkg ST_* encoding)
module key_debounce_pulse
    import key_pkg::*;
#(
    parameter int DB_CYCLES     = DB_CYCLES_DEFAULT,
    parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEFAULT
) (
    input  logic       ck,
    input  logic       res,
    input  logic       key_n,
    output logic       key_level,
    output logic       press_pulse,
    output logic       rel_pulse,
    output logic [1:0] dbg_state
);

    if (DB_CYCLES < 2 || DB_CYCLES > 65535 || REPEAT_CYCLES < 2) begin : g_param_check
        $error("key_debounce_pulse: DB_CYCLES or REPEAT_CYCLES out of range");
    end

    localparam int CNT_W = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    // Synchroniser resets to 1 so the key reads as released out of reset.
    logic key_n_sync;
    logic key_s;

    sync_2ff #(
        .WIDTH   (1),
        .RST_VAL (1'b1)
    ) u_sync (
        .clk   (ck),
        .rst_n (res),
        .d     (key_n),
        .q     (key_n_sync)
    );

    assign key_s = ~key_n_sync;

    logic [1:0]       state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             key_level_d, key_level_q;
    logic             press_pulse_d, press_pulse_q;
    logic             rel_pulse_d, rel_pulse_q;
    logic             press_fire;
    logic             rel_fire;
    logic             rpt_fire;

    // Debounce FSM. The counter is cleared on every state entry and compared
    // with ==, so it never wraps and never accumulates across bounces.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RELEASED: begin
                if (key_s) begin
                    state_d = ST_WAIT_PRESS;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_PRESS: begin
                if (!key_s) begin
                    state_d = ST_RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_PRESSED: begin
                if (!key_s) begin
                    state_d = ST_WAIT_RELEASE;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_RELEASE: begin
                if (key_s) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_RELEASED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    assign press_fire = (state_q == ST_WAIT_PRESS)   && (state_d == ST_PRESSED);
    assign rel_fire   = (state_q == ST_WAIT_RELEASE) && (state_d == ST_RELEASED);

`ifdef KEY_DEBOUNCE_AUTO_REPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_CYCLES);
    localparam logic [RPT_W-1:0] RPT_MAX = RPT_W'(REPEAT_CYCLES - 1);

    logic [RPT_W-1:0] rpt_cnt_d, rpt_cnt_q;
    logic             stay_pressed;

    // Only counts while staying in PRESSED; a pending release (leaving for
    // WAIT_RELEASE) clears it and suppresses the repeat.
    assign stay_pressed = (state_q == ST_PRESSED) && (state_d == ST_PRESSED);
    assign rpt_fire     = stay_pressed && (rpt_cnt_q == RPT_MAX);

    always_comb begin
        rpt_cnt_d = '0;
        if (stay_pressed && !rpt_fire) begin
            rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
        end
    end

    always_ff @(posedge ck or negedge res) begin
        if (!res) begin
            rpt_cnt_q <= '0;
        end else begin
            rpt_cnt_q <= rpt_cnt_d;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    // Outputs are registered from the next-state decode so they line up with
    // the cycle in which the FSM has entered the new state.
    always_comb begin
        key_level_d   = (state_d == ST_PRESSED) || (state_d == ST_WAIT_RELEASE);
        press_pulse_d = press_fire || rpt_fire;
        rel_pulse_d   = rel_fire;
    end

    always_ff @(posedge ck or negedge res) begin
        if (!res) begin
            state_q       <= ST_RELEASED;
            cnt_q         <= '0;
            key_level_q   <= 1'b0;
            press_pulse_q <= 1'b0;
            rel_pulse_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            key_level_q   <= key_level_d;
            press_pulse_q <= press_pulse_d;
            rel_pulse_q   <= rel_pulse_d;
        end
    end

    assign key_level   = key_level_q;
    assign press_pulse = press_pulse_q;
    assign rel_pulse   = rel_pulse_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_key_debounce_pulse.sv
// tb_key_debounce_pulse: self-checking bench for key_debounce_pulse.
// Expected pulse events ({is_press, edge number}) are queued when key_n is
// driven and popped when the DUT raises press_pulse or rel_pulse.
`timescale 1ps/1ps
module tb_key_debounce_pulse;

    localparam int STEP = 100000;
    localparam int DB   = 4;
    localparam int RPT  = 8;
    // Drive at a falling edge; first sample is the next rising edge k;
    // the pulse is visible after edge k+2+DB.
    localparam int LAT  = 1 + 2 + DB;

    logic       ck    = 1'b0;
    logic       res   = 1'b0;
    logic       key_n = 1'b1;
    logic       key_level;
    logic       press_pulse;
    logic       rel_pulse;
    logic [1:0] dbg_state;

    logic [3:0]  q;
    logic [3:0]  q_exp    = 4'd0;
    int          edge_cnt = 0;
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #(STEP / 2) ck = ~ck;

    key_debounce_pulse #(
        .DB_CYCLES     (DB),
        .REPEAT_CYCLES (RPT)
    ) dut (
        .ck          (ck),
        .res         (res),
        .key_n       (key_n),
        .key_level   (key_level),
        .press_pulse (press_pulse),
        .rel_pulse   (rel_pulse),
        .dbg_state   (dbg_state)
    );

    // Downstream 4-bit counter enabled by press_pulse.
    always_ff @(posedge ck or negedge res) begin
        if (!res) q <= 4'd0;
        else if (press_pulse) q <= q + 4'd1;
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got=%0h expected=%0h (edge %0d)", tag, got, exp, edge_cnt);
        end
    endtask

    function automatic logic [31:0] ev(input logic is_press, input int at);
        logic [31:0] e;
        e = at;
        e[31] = is_press;
        return e;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic expect_press(input int at);
        exp_q.push_back(ev(1'b1, at));
        q_exp = q_exp + 4'd1;
    endtask

    task automatic expect_rel(input int at);
        exp_q.push_back(ev(1'b0, at));
    endtask

    // Called at a falling edge; returns at a falling edge.
    task automatic hold_key(input logic v, input int cycles);
        key_n = v;
        repeat (cycles) @(negedge ck);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(posedge ck) begin
        logic [31:0] got;
        logic [31:0] exp;
        edge_cnt++;
        #1;
        while (exp_q.size() > 0 && exp_q[0][30:0] < edge_cnt[30:0]) begin
            check_eq("missed_pulse", ev(1'b1, edge_cnt), exp_q.pop_front());
        end
        if (press_pulse || rel_pulse) begin
            check_eq("pulse_excl", {31'd0, press_pulse & rel_pulse}, 32'd0);
            got = ev(press_pulse, edge_cnt);
            if (exp_q.size() > 0) exp = exp_q.pop_front();
            else exp = 32'hffff_ffff;
            check_eq("pulse", got, exp);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        res   = 1'b0;
        key_n = 1'b1;
        repeat (3) @(negedge ck);
        check_eq("rst_level", {31'd0, key_level}, 32'd0);
        check_eq("rst_press", {31'd0, press_pulse}, 32'd0);
        check_eq("rst_rel",   {31'd0, rel_pulse}, 32'd0);
        check_eq("rst_state", {30'd0, dbg_state}, 32'd0);
        res = 1'b1;
        repeat (2) @(negedge ck);

        // Clean press then clean release.
        expect_press(edge_cnt + LAT);
        hold_key(1'b0, 10);
        check_eq("press_level", {31'd0, key_level}, 32'd1);
        check_eq("press_q", {28'd0, q}, {28'd0, q_exp});
        expect_rel(edge_cnt + LAT);
        hold_key(1'b1, 10);
        check_eq("rel_level", {31'd0, key_level}, 32'd0);

        // Bouncing press: only the final stable 0 counts.
        hold_key(1'b0, 1);
        hold_key(1'b1, 1);
        hold_key(1'b0, 1);
        hold_key(1'b1, 1);
        expect_press(edge_cnt + LAT);
        hold_key(1'b0, 10);
        check_eq("bounce_level", {31'd0, key_level}, 32'd1);
        check_eq("bounce_q", {28'd0, q}, {28'd0, q_exp});

        // 2-cycle release glitch is rejected, then a clean release.
        hold_key(1'b1, 2);
        hold_key(1'b0, 6);
        check_eq("relglitch_level", {31'd0, key_level}, 32'd1);
        expect_rel(edge_cnt + LAT);
        hold_key(1'b1, 10);
        check_eq("rel2_level", {31'd0, key_level}, 32'd0);

        // Short press glitches (below DB cycles) produce nothing.
        hold_key(1'b0, 3);
        hold_key(1'b1, 10);
        check_eq("glitch_level", {31'd0, key_level}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            hold_key(1'b0, $urandom_range(DB - 1, 1));
            hold_key(1'b1, $urandom_range(3, 1));
        end
        hold_key(1'b1, 8);
        check_eq("rglitch_level", {31'd0, key_level}, 32'd0);
        check_eq("glitch_q", {28'd0, q}, {28'd0, q_exp});

        // Reset in the middle of a press pulse with the key held down.
        expect_press(edge_cnt + LAT);
        hold_key(1'b0, LAT);
        check_eq("pre_rst_pulse", {31'd0, press_pulse}, 32'd1);
        res = 1'b0;
        #1;
        check_eq("mid_rst_level", {31'd0, key_level}, 32'd0);
        check_eq("mid_rst_press", {31'd0, press_pulse}, 32'd0);
        check_eq("mid_rst_rel",   {31'd0, rel_pulse}, 32'd0);
        check_eq("mid_rst_state", {30'd0, dbg_state}, 32'd0);
        repeat (3) @(negedge ck);
        q_exp = 4'd0;
        expect_press(edge_cnt + LAT);
        res = 1'b1;
        hold_key(1'b0, 10);
        check_eq("held_rst_level", {31'd0, key_level}, 32'd1);
        check_eq("held_rst_q", {28'd0, q}, {28'd0, q_exp});
        expect_rel(edge_cnt + LAT);
        hold_key(1'b1, 10);

        // Long hold: auto-repeat pulses only when the feature is built.
        begin
            int t0;
            t0 = edge_cnt + LAT;
            expect_press(t0);
`ifdef KEY_DEBOUNCE_AUTO_REPEAT_EN
            expect_press(t0 + RPT);
            expect_press(t0 + 2 * RPT);
            expect_press(t0 + 3 * RPT);
`endif
            hold_key(1'b0, 30);
            check_eq("hold_q", {28'd0, q}, {28'd0, q_exp});
            expect_rel(edge_cnt + LAT);
            hold_key(1'b1, 10);
            check_eq("hold_rel_level", {31'd0, key_level}, 32'd0);
        end

        repeat (5) @(negedge ck);
        check_eq("queue_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/key_debounce_pulse.md
Name: key_debounce_pulse

Overview:
- Input conditioning stage that sits directly upstream of the 4-bit counter.
- Takes a raw, bouncing, active-low push-button and synchronises it to ck.
- Debounces the button and produces a clean level plus single-cycle press/release pulses.
- press_pulse drives the counter's count-enable, so one physical press advances q by exactly one.

Parameters:
- DB_CYCLES, 4: consecutive stable cycles required to accept a level change; legal range 2..65535.
- REPEAT_CYCLES, 8: auto-repeat period in cycles while held; used only when KEY_DEBOUNCE_AUTO_REPEAT_EN is defined; legal minimum 2.

Ports:
- ck  input  1  clock; all state updates on rising edge.
- res  input  1  asynchronous active-low reset; 0 clears all state immediately, deassertion is synchronous to ck externally.
- key_n  input  1  raw button, active-low (0 = pressed), asynchronous to ck, may bounce.
- key_level  output  1  debounced pressed level (1 = pressed).
- press_pulse  output  1  one-cycle pulse on accepted press.
- rel_pulse  output  1  one-cycle pulse on accepted release.

Behaviour:
- Synchroniser
  - Two flops sample key_n.
  - key_s = inverted second-flop output.
  - Both flops reset to 1, i.e. released.
- Debounce counter
  - Width CNT_W = clog2(DB_CYCLES).
  - Resets to 0.
- FSM states, encoded in package; reset state RELEASED:
  - RELEASED: key_s=1 -> WAIT_PRESS, cnt<=0; otherwise stay.
  - WAIT_PRESS: key_s=0 -> RELEASED (bounce rejected), cnt<=0. key_s=1 and cnt==DB_CYCLES-1 -> PRESSED. Otherwise cnt++.
  - PRESSED: key_s=0 -> WAIT_RELEASE, cnt<=0; otherwise stay.
  - WAIT_RELEASE: key_s=1 -> PRESSED, cnt<=0. key_s=0 and cnt==DB_CYCLES-1 -> RELEASED. Otherwise cnt++.
- Outputs are registered; reset values: key_level=0, press_pulse=0, rel_pulse=0.
  - key_level = 1 in PRESSED and WAIT_RELEASE.
  - press_pulse = 1 for exactly the cycle after the WAIT_PRESS->PRESSED transition.
  - rel_pulse = 1 for exactly the cycle after the WAIT_RELEASE->RELEASED transition.
- Latency: a clean key_n change first sampled at edge k gives key_level/pulse high after edge k+2+DB_CYCLES. With DB_CYCLES=4 this is 6 edges.
- Boundary conditions:
  - Glitch shorter than DB_CYCLES cycles (after sync): no output change, no pulse.
  - Bounce in WAIT state: restarts from the stable state; the counter does not accumulate across bounces.
  - press_pulse and rel_pulse are never high in the same cycle; pulses are at least DB_CYCLES+1 cycles apart.
  - Reset mid-debounce or mid-pulse: all outputs 0 immediately, state RELEASED.
  - Button held through reset deassertion: after deassertion the normal press path is taken, giving one press_pulse after DB_CYCLES+2 cycles.
  - Counter never wraps: it is cleared on every state entry and compares with ==.

Optional Feature:
- Macro: KEY_DEBOUNCE_AUTO_REPEAT_EN.
- Defined:
  - A repeat counter (width clog2(REPEAT_CYCLES)) runs while in PRESSED.
  - Every REPEAT_CYCLES cycles in PRESSED it issues an additional one-cycle press_pulse.
  - The first repeat pulse comes REPEAT_CYCLES cycles after the initial press_pulse.
  - The repeat counter clears on leaving PRESSED.
  - WAIT_RELEASE suppresses repeats.
- Undefined: no repeat counter is built; exactly one press_pulse per accepted press.

Decomposition:
- Shared package key_pkg:
  - State encoding localparams ST_RELEASED=2'd0, ST_WAIT_PRESS=2'd1, ST_PRESSED=2'd2, ST_WAIT_RELEASE=2'd3.
  - Default DB_CYCLES and REPEAT_CYCLES constants.
- Sub-module sync_2ff:
  - Two-flop synchroniser with async active-low reset and a reset-value parameter.
  - Reused for other asynchronous inputs.

Test Plan:
All scenarios use STEP=100000 ps, DB_CYCLES=4.
- Reset: res=0 mid-run with key_n=0 held -> key_level=0, press_pulse=0, rel_pulse=0 within the same timestep. After release of res: press_pulse high at edge 6, exactly 1 cycle.
- Clean press: key_n 1->0 held 10 cycles -> press_pulse high for 1 cycle, 6 edges after first sample; key_level=1 from that cycle. Counter fed by press_pulse advances q from 0 to 1.
- Bounce rejection: key_n toggles 0,1,0,1 each cycle, then holds 0 -> exactly one press_pulse, 6 edges after the final stable 0 is sampled.
- Short glitch: key_n low for 3 cycles then high -> no pulses, key_level stays 0.
- Release: from PRESSED, key_n 0->1 held -> rel_pulse 1 cycle after 6 edges, key_level=0. A 2-cycle release glitch gives no rel_pulse.
- Auto-repeat (macro defined, REPEAT_CYCLES=8): hold key_n=0 for 30 cycles -> press_pulses at t0, t0+8, t0+16, t0+24. With the macro undefined, only t0.
